// File: rtl/mem_reader_if.sv
// Bundle of the start/memory/serial-stream signals shared by mem_reader and its environment.
// slave is the reader's side; master is the controller/memory/sink side.
interface mem_reader_if #(
  parameter int MEM_ADDR_WIDTH = 5,
  parameter int MEM_DATA_WIDTH = 8
);
  logic                      I_start;
  logic [MEM_ADDR_WIDTH-1:0] I_st_addr;
  logic [MEM_ADDR_WIDTH:0]   I_len;
  logic [MEM_ADDR_WIDTH-1:0] O_ext_addr;
  logic [MEM_DATA_WIDTH-1:0] I_ext_data;
  logic                      O_sdata;
  logic                      O_svalid;
  logic                      I_sready;
  logic                      O_busy;
  logic                      O_done;

  modport slave (
    input  I_start, I_st_addr, I_len, I_ext_data, I_sready,
    output O_ext_addr, O_sdata, O_svalid, O_busy, O_done
  );

  modport master (
    output I_start, I_st_addr, I_len, I_ext_data, I_sready,
    input  O_ext_addr, O_sdata, O_svalid, O_busy, O_done
  );
endinterface

// File: rtl/mem_reader.sv
// Dumps a run of syn_mem words as a serial MSB-first bit stream with valid/ready flow control.
// The memory has one cycle of read latency, hence the RD/LD pair between words.
module mem_reader #(
  parameter int MEM_ADDR_WIDTH = 5,
  parameter int MEM_DATA_WIDTH = 8
) (
  input  logic          I_clk,
  input  logic          I_rst,
  mem_reader_if.slave   bus
);

  localparam int BW = (MEM_DATA_WIDTH > 1) ? $clog2(MEM_DATA_WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] LD   = 2'd2;
  localparam logic [1:0] SH   = 2'd3;

  localparam logic [BW-1:0]             LastBit = BW'(MEM_DATA_WIDTH - 1);
  localparam logic [BW-1:0]             BitOne  = BW'(1);
  localparam logic [MEM_ADDR_WIDTH:0]   RemOne  = (MEM_ADDR_WIDTH + 1)'(1);
  localparam logic [MEM_ADDR_WIDTH-1:0] AddrOne = MEM_ADDR_WIDTH'(1);

  logic [1:0]                state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_ADDR_WIDTH:0]   rem_q, rem_d;
  logic [MEM_DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]             bitcnt_q, bitcnt_d;
  logic                      svalid_q, svalid_d;
  logic                      done_q, done_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    svalid_d = svalid_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.I_start) begin
          if (bus.I_len != '0) begin
            rem_d   = bus.I_len;
            addr_d  = bus.I_st_addr;
            state_d = RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD: state_d = LD;
      LD: begin
        shreg_d  = bus.I_ext_data;
        bitcnt_d = '0;
        rem_d    = rem_q - RemOne;
        svalid_d = 1'b1;
        state_d  = SH;
      end
      SH: begin
        if (svalid_q && bus.I_sready) begin
          shreg_d  = {shreg_q[MEM_DATA_WIDTH-2:0], 1'b0};
          bitcnt_d = bitcnt_q + BitOne;
          if (bitcnt_q == LastBit) begin
            svalid_d = 1'b0;
            if (rem_q != '0) begin
              addr_d  = addr_q + AddrOne;  // wraps modulo the memory depth
              state_d = RD;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      svalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      svalid_q <= svalid_d;
      done_q   <= done_d;
    end
  end

  assign bus.O_ext_addr = addr_q;
  assign bus.O_sdata    = shreg_q[MEM_DATA_WIDTH-1];
  assign bus.O_svalid   = svalid_q;
  assign bus.O_busy     = (state_q != IDLE);
  assign bus.O_done     = done_q;

endmodule

// File: tb/tb_mem_reader.sv
// Scoreboard bench for mem_reader: stimulus pushes expected bits/done pulses, a negedge
// monitor pops and compares whenever the DUT transfers a bit or pulses done.
module tb_mem_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_reader_if #(.MEM_ADDR_WIDTH(5), .MEM_DATA_WIDTH(8)) bus ();

  mem_reader #(.MEM_ADDR_WIDTH(5), .MEM_DATA_WIDTH(8)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  logic [7:0] mem [32];
  always @(posedge clk) bus.I_ext_data <= mem[bus.O_ext_addr];

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  int   done_exp  = 0;
  int   done_seen = 0;
  int   gap       = 0;
  logic stall_prev = 1'b0;
  logic stall_bit  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic do_start(input logic [4:0] a, input logic [5:0] l);
    @(posedge clk); #1;
    bus.I_start = 1'b1; bus.I_st_addr = a; bus.I_len = l;
    @(posedge clk); #1;
    bus.I_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base;
    base = done_seen;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_seen > base) break;
    end
    check("done_timeout", int'(done_seen > base), 1);
    #1;
  endtask

  // Monitor: bit transfers, done pulses, stall stability and inter-word gaps
  always @(negedge clk) begin
    if (rst) begin
      gap = 0;
      stall_prev = 1'b0;
    end else begin
      if (bus.O_done) begin
        check("done_expected", int'(done_exp > 0), 1);
        check("done_no_svalid", int'(bus.O_svalid), 0);
        check("done_queue_empty", exp_q.size(), 0);
        if (done_exp > 0) done_exp--;
        done_seen++;
      end
      if (bus.O_svalid) begin
        if (gap != 0) check("word_gap", gap, 2);
        gap = 0;
      end else if (bus.O_busy) begin
        gap++;
      end else begin
        gap = 0;
      end
      if (stall_prev && bus.O_svalid) check("stall_hold", int'(bus.O_sdata), int'(stall_bit));
      stall_prev = bus.O_svalid && !bus.I_sready;
      stall_bit  = bus.O_sdata;
      if (bus.O_svalid && bus.I_sready) begin
        if (exp_q.size() == 0) check("unexpected_bit", 1, 0);
        else check("bit", int'(bus.O_sdata), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 3);
    mem[1] = 8'hA5; mem[2] = 8'h3C; mem[31] = 8'h81; mem[0] = 8'h7E;
    bus.I_start = 1'b0; bus.I_st_addr = '0; bus.I_len = '0; bus.I_sready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", int'(bus.O_ext_addr), 0);
    check("rst_sdata", int'(bus.O_sdata), 0);
    check("rst_svalid", int'(bus.O_svalid), 0);
    check("rst_busy", int'(bus.O_busy), 0);
    check("rst_done", int'(bus.O_done), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Two-word dump at full rate
    push_word(8'hA5); push_word(8'h3C); done_exp++;
    do_start(5'd1, 6'd2);
    @(negedge clk);
    check("start_addr", int'(bus.O_ext_addr), 1);
    check("start_busy", int'(bus.O_busy), 1);
    check("start_svalid", int'(bus.O_svalid), 0);
    wait_done(100);
    check("end_addr", int'(bus.O_ext_addr), 2);
    check("end_busy", int'(bus.O_busy), 0);

    // Zero length: done next cycle, nothing else moves
    done_exp++;
    do_start(5'd7, 6'd0);
    @(negedge clk);
    check("len0_done", int'(bus.O_done), 1);
    check("len0_svalid", int'(bus.O_svalid), 0);
    check("len0_addr", int'(bus.O_ext_addr), 2);
    check("len0_busy", int'(bus.O_busy), 0);
    @(negedge clk);
    check("len0_done_once", int'(bus.O_done), 0);

    // Alternating backpressure
    push_word(8'hA5); done_exp++;
    base = done_seen;
    bus.I_sready = 1'b0;
    do_start(5'd1, 6'd1);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1 bus.I_sready = ~bus.I_sready;
      if (done_seen > base) break;
    end
    bus.I_sready = 1'b1;
    check("stall_done", int'(done_seen > base), 1);

    // Address wrap 31 -> 0
    push_word(8'h81); push_word(8'h7E); done_exp++;
    do_start(5'd31, 6'd2);
    @(negedge clk);
    check("wrap_first_addr", int'(bus.O_ext_addr), 31);
    wait_done(100);
    check("wrap_last_addr", int'(bus.O_ext_addr), 0);

    // Reset after 3 bits, then a clean restart
    push_word(8'hA5);
    do_start(5'd1, 6'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (exp_q.size() == 5) break;
    end
    check("abort_reached_bit3", exp_q.size(), 5);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_svalid", int'(bus.O_svalid), 0);
    check("abort_busy", int'(bus.O_busy), 0);
    check("abort_done", int'(bus.O_done), 0);
    check("abort_addr", int'(bus.O_ext_addr), 0);
    exp_q.delete();
    push_word(8'hA5); done_exp++;
    do_start(5'd1, 6'd1);
    wait_done(100);

    // Reset wins over a simultaneous start
    @(posedge clk); #1;
    rst = 1'b1; bus.I_start = 1'b1; bus.I_st_addr = 5'd4; bus.I_len = 6'd3;
    @(posedge clk); #1;
    rst = 1'b0; bus.I_start = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", int'(bus.O_busy), 0);
    check("rst_prio_addr", int'(bus.O_ext_addr), 0);

    // Second start mid-dump is ignored
    push_word(8'hA5); push_word(8'h3C); done_exp++;
    do_start(5'd1, 6'd2);
    repeat (6) @(posedge clk);
    do_start(5'd5, 6'd3);
    wait_done(100);
    check("ignore_end_addr", int'(bus.O_ext_addr), 2);

    repeat (4) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("all_done_seen", done_exp, 0);
    check("idle_at_end", int'(bus.O_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 5, meaning the syn_mem address width.
REQ-002 SHALL have parameter MEM_DATA_WIDTH, default 8, meaning the syn_mem word width and the number of serial bits per word.
REQ-003 SHALL have port I_clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port I_rst  input  1  meaning the reset, which is synchronous and active-high.
REQ-005 SHALL have port I_start  input  1  meaning the dump request, sampled only in IDLE.
REQ-006 SHALL have port I_st_addr  input  MEM_ADDR_WIDTH  meaning the first word address, latched with I_start.
REQ-007 SHALL have port I_len  input  MEM_ADDR_WIDTH+1  meaning the number of words to dump, latched with I_start.
REQ-008 SHALL have port O_ext_addr  output  MEM_ADDR_WIDTH  meaning the registered address driven to the syn_mem I_ext_addr port.
REQ-009 SHALL have port I_ext_data  input  MEM_DATA_WIDTH  meaning the syn_mem O_ext_data, valid one edge after the address is sampled.
REQ-010 SHALL have port O_sdata  output  1  meaning the serial data bit, MSB first.
REQ-011 SHALL have port O_svalid  output  1  meaning O_sdata holds a valid bit.
REQ-012 SHALL have port I_sready  input  1  meaning the sink accepts the bit; transfer = O_svalid & I_sready at an edge.
REQ-013 SHALL have port O_busy  output  1  meaning the block is not in IDLE.
REQ-014 SHALL have port O_done  output  1  meaning a one-cycle pulse at dump completion.

Function
REQ-015 SHALL implement the states IDLE, RD, LD and SH.
REQ-016 IDLE: if I_start=1 and I_len!=0, SHALL latch I_len into the remaining-word count, set O_ext_addr=I_st_addr, and go to RD.
REQ-017 IDLE: if I_start=1 and I_len=0, SHALL pulse O_done on the next cycle, stay in IDLE, and leave O_ext_addr unchanged.
REQ-018 RD: SHALL go to LD unconditionally; syn_mem samples O_ext_addr at this edge.
REQ-019 LD: SHALL load I_ext_data into the shift register, clear the bit counter, decrement the remaining-word count, set O_svalid=1, and go to SH.
REQ-020 SH: O_sdata SHALL equal the shift register MSB; O_sdata and O_svalid SHALL stay stable while I_sready=0.
REQ-021 SH: on each transfer, SHALL shift left by one and increment the bit counter.
REQ-022 SH: on the transfer of bit MEM_DATA_WIDTH-1 with the remaining count !=0, SHALL set O_svalid=0, set O_ext_addr to O_ext_addr+1 modulo 2^MEM_ADDR_WIDTH, and go to RD.
REQ-023 SH: on the transfer of bit MEM_DATA_WIDTH-1 with the remaining count =0, SHALL set O_svalid=0, pulse O_done for one cycle, and go to IDLE.
REQ-024 Latency: O_svalid SHALL rise after the second edge following the edge that samples I_start; the inter-word gap SHALL be exactly 2 cycles with O_svalid=0.
REQ-025 I_start while O_busy=1 SHALL be ignored; the latched address and count SHALL be unaffected.
REQ-026 I_len > 2^MEM_ADDR_WIDTH SHALL be legal; the address wraps and words are re-read in order.
REQ-027 O_busy SHALL be 1 exactly in RD, LD and SH.
REQ-028 O_done and O_svalid SHALL never be 1 in the same cycle.

Reset
REQ-029 I_rst=1 at an edge SHALL force IDLE, O_ext_addr=0, O_sdata=0, O_svalid=0, O_busy=0, O_done=0, and clear the shift register and both counters, even mid-word.
REQ-030 Reset SHALL take priority over I_start in the same cycle; no O_done SHALL be produced for an aborted dump.

Verification
REQ-031 Memory [1]=0xA5, [2]=0x3C; start with I_st_addr=1, I_len=2, I_sready=1 -> bits 10100101 then 00111100; 2-cycle gap between words; O_done pulses once, one cycle after the last transfer edge.
REQ-032 I_len=0 -> O_done pulses on the next cycle; O_svalid stays 0 and O_ext_addr is unchanged.
REQ-033 I_sready toggled 0/1 on alternating cycles during the word 0xA5 -> the same 8-bit sequence; O_sdata is held while stalled.
REQ-034 I_st_addr=31, I_len=2, [31]=0x81, [0]=0x7E -> O_ext_addr goes 31 then 0; the stream is 0x81 then 0x7E.
REQ-035 Assert I_rst after 3 bits of the first word -> next cycle O_svalid=0, O_busy=0, no O_done; a fresh start then dumps correctly from bit 7.
REQ-036 A second I_start pulse mid-dump with different I_st_addr and I_len -> ignored; the original stream completes unchanged.
